data_memory_responder: RTL

//  Responder end of the MEM-stage data-memory interface. Accepts load/store

---
 rtl/data_memory_responder_pkg.sv | 23 ++
 rtl/data_memory_responder_sync_ram_sp.sv | 31 +++
 rtl/data_memory_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: FSM state
// encodings, parameter defaults and the latency counter width.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int DEPTH_DEF   = 256;
  localparam int LATENCY_DEF = 2;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] wait_count(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/data_memory_responder_sync_ram_sp.sv
// Single-port word array: one write or one read per cycle, registered read.
// The read register only changes on a read, so it holds across response stalls.
module data_memory_responder_sync_ram_sp #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Responder end of the MEM-stage data-memory interface: accepts one load/store,
// performs it after LATENCY cycles and holds the response until consumed.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              rdata_sel_q, rdata_sel_d;

  logic              addr_ok;
  logic              access;
  logic [DATA_W-1:0] ram_rdata;

  assign addr_ok = ({1'b0, addr_q} < DEPTH_EXT);
  // The array is touched only on the final WAIT cycle; its registered read
  // lands on the same edge that raises resp_valid.
  assign access  = (state_q == S_WAIT) && (cnt_q == '0);

  data_memory_responder_sync_ram_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (access && addr_ok),
    .we    (write_q),
    .addr  (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    rdata_sel_d  = rdata_sel_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = wait_count(LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = !addr_ok;
          rdata_sel_d  = !write_q && addr_ok;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          rdata_sel_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_sel_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_sel_q  <= rdata_sel_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  // Stores and errors return zero; loads expose the held array read register.
  assign resp_rdata = rdata_sel_q ? ram_rdata : '0;

endmodule
